// File: rtl/elevator_controller.sv
// Elevator car sequencer.
// Latches floor calls, serves them with a collective (SCAN) policy, and times
// the floor-to-floor travel and the door dwell from an external tick. The
// floor number and direction status drive the seven-segment display directly.
module elevator_controller #(
  parameter int NUM_FLOORS = 10,  // 2..10, so the floor index fits one digit
  parameter int MOVE_TICKS = 4,   // ticks to travel one floor, >= 1
  parameter int DOOR_TICKS = 6    // ticks the door stays open, >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [3:0]            floor,
  output logic [1:0]            status,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  // Counter widths; a one-tick phase still needs a 1-bit counter.
  localparam int MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);
  localparam logic [3:0]    TOP_FLOOR = 4'(NUM_FLOORS - 1);

  // Status codes as shown on display digit 3 (10 + status: A, b, C).
  localparam logic [1:0] ST_UP     = 2'b00;
  localparam logic [1:0] ST_DOWN   = 2'b01;
  localparam logic [1:0] ST_STABLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  state_t          state;
  dir_t            dir;
  logic [MW-1:0]   move_cnt;
  logic [DW-1:0]   door_cnt;

  // Combinational view of the registered call set relative to the car.
  logic [NUM_FLOORS-1:0] pend_in;   // pending plus this cycle's buttons
  logic [NUM_FLOORS-1:0] cur_oh;    // one-hot of the current floor
  logic [NUM_FLOORS-1:0] up_oh;     // one-hot of the floor above
  logic [NUM_FLOORS-1:0] dn_oh;     // one-hot of the floor below
  logic                  above;
  logic                  below;
  logic                  here_pend;
  logic                  up_pend;
  logic                  dn_pend;
  logic                  door_recall;
  logic                  move_done;
  logic                  door_done;

  // Decode floor masks and the above/below request summaries.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned; a missing default here would infer a latch.
    pend_in = pending | call_req;
    cur_oh  = '0;
    up_oh   = '0;
    dn_oh   = '0;
    above   = 1'b0;
    below   = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_oh[i] = (floor == 4'(i));
      up_oh[i]  = ((floor + 4'd1) == 4'(i));
      // At floor 0 this wraps to 15, which matches no floor index.
      dn_oh[i]  = ((floor - 4'd1) == 4'(i));
      if (4'(i) > floor) above = above | pending[i];
      if (4'(i) < floor) below = below | pending[i];
    end
    here_pend   = |(pending & cur_oh);
    up_pend     = |(pending & up_oh);
    dn_pend     = |(pending & dn_oh);
    // A button at the current floor while the door is open only extends the
    // dwell; it never becomes a pending call.
    door_recall = |(call_req & cur_oh);
    move_done   = tick && (move_cnt == MOVE_LAST);
    door_done   = tick && (door_cnt == DOOR_LAST);
  end

  // Car sequencer: state, direction, counters, call register and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      move_cnt  <= '0;
      door_cnt  <= '0;
      floor     <= 4'd0;
      status    <= ST_STABLE;
      door_open <= 1'b0;
      pending   <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every branch
      // reads the pre-edge values of pending, floor and the counters.
      pending <= pend_in;

      case (state)
        IDLE: begin
          status    <= ST_STABLE;
          door_open <= 1'b0;
          if (here_pend) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= '0;
            pending   <= pend_in & ~cur_oh;
          end else if (above && (dir == DIR_UP || !below)) begin
            state    <= MOVE_UP;
            status   <= ST_UP;
            dir      <= DIR_UP;
            move_cnt <= '0;
          end else if (below) begin
            state    <= MOVE_DOWN;
            status   <= ST_DOWN;
            dir      <= DIR_DOWN;
            move_cnt <= '0;
          end
        end

        MOVE_UP: begin
          if (move_done) begin
            move_cnt <= '0;
            floor    <= floor + 4'd1;
            // Stop only if the floor being reached has a call; otherwise a
            // call further up must still exist, so keep travelling.
            if (up_pend) begin
              state     <= DOOR;
              status    <= ST_STABLE;
              door_open <= 1'b1;
              door_cnt  <= '0;
              pending   <= pend_in & ~up_oh;
            end
          end else if (tick) begin
            move_cnt <= move_cnt + 1'b1;
          end
        end

        MOVE_DOWN: begin
          if (move_done) begin
            move_cnt <= '0;
            floor    <= floor - 4'd1;
            if (dn_pend) begin
              state     <= DOOR;
              status    <= ST_STABLE;
              door_open <= 1'b1;
              door_cnt  <= '0;
              pending   <= pend_in & ~dn_oh;
            end
          end else if (tick) begin
            move_cnt <= move_cnt + 1'b1;
          end
        end

        DOOR: begin
          // The served floor stays clear for the whole dwell.
          pending <= pend_in & ~cur_oh;
          if (door_recall) begin
            door_cnt <= '0;
          end else if (door_done) begin
            door_cnt  <= '0;
            door_open <= 1'b0;
            // Keep sweeping the same way while calls remain ahead, then
            // reverse, and only park when nothing is left.
            if (dir == DIR_UP && above) begin
              state    <= MOVE_UP;
              status   <= ST_UP;
              move_cnt <= '0;
            end else if (dir == DIR_DOWN && below) begin
              state    <= MOVE_DOWN;
              status   <= ST_DOWN;
              move_cnt <= '0;
            end else if (dir == DIR_UP && below) begin
              state    <= MOVE_DOWN;
              status   <= ST_DOWN;
              dir      <= DIR_DOWN;
              move_cnt <= '0;
            end else if (dir == DIR_DOWN && above) begin
              state    <= MOVE_UP;
              status   <= ST_UP;
              dir      <= DIR_UP;
              move_cnt <= '0;
            end else begin
              state  <= IDLE;
              status <= ST_STABLE;
            end
          end else if (tick) begin
            door_cnt <= door_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          status    <= ST_STABLE;
          door_open <= 1'b0;
        end
      endcase
    end
  end

  // Being in a move state at the end of the shaft means the scheduler chose
  // a direction with no call ahead; the next arrival would leave the shaft.
  a_no_overrun_top : assert property (@(posedge clk) disable iff (rst)
    !(state == MOVE_UP && floor == TOP_FLOOR));

  a_no_overrun_bottom : assert property (@(posedge clk) disable iff (rst)
    !(state == MOVE_DOWN && floor == 4'd0));

  a_floor_in_range : assert property (@(posedge clk) disable iff (rst)
    floor <= TOP_FLOOR);

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with MOVE_TICKS=2, DOOR_TICKS=3.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_elevator_controller;

  localparam int NF = 10;
  localparam int MT = 2;
  localparam int DT = 3;

  localparam int ST_UP     = 0;
  localparam int ST_DOWN   = 1;
  localparam int ST_STABLE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic [3:0]    floor;
  logic [1:0]    status;
  logic          door_open;
  logic [NF-1:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  int seq_q[$];
  int stop_q[$];
  int max_fl;

  elevator_controller #(
    .NUM_FLOORS (NF),
    .MOVE_TICKS (MT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .call_req  (call_req),
    .floor     (floor),
    .status    (status),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button mask for exactly one clock.
  task automatic pulse(input logic [NF-1:0] m);
    call_req = m;
    step(1);
    call_req = '0;
  endtask

  task automatic wait_floor(input int f, input int budget);
    int k;
    k = 0;
    while (int'(floor) != f && k < budget) begin
      step(1);
      k++;
    end
    check($sformatf("reach_floor_%0d", f), int'(floor), f);
  endtask

  // Follow the car until it parks, logging status changes, door stops and
  // the highest floor seen.
  task automatic run_route(input int budget);
    int   prev_st;
    logic prev_door;
    int   k;
    seq_q.delete();
    stop_q.delete();
    prev_st   = int'(status);
    prev_door = door_open;
    max_fl    = int'(floor);
    seq_q.push_back(int'(status));
    k = 0;
    while (!(int'(status) == ST_STABLE && !door_open && pending == '0) && k < budget) begin
      step(1);
      k++;
      if (int'(status) != prev_st) seq_q.push_back(int'(status));
      prev_st = int'(status);
      if (door_open && !prev_door) stop_q.push_back(int'(floor));
      prev_door = door_open;
      if (int'(floor) > max_fl) max_fl = int'(floor);
    end
    check("route_parks_in_budget", int'(k < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_seq[6];
    int exp_b[4];

    // Reset state while rst is held.
    step(2);
    check("rst_floor", int'(floor), 0);
    check("rst_status", int'(status), ST_STABLE);
    check("rst_door", int'(door_open), 0);
    check("rst_pending", int'(pending), 0);
    rst  = 1'b0;
    tick = 1'b1;
    step(1);

    // Current-floor call: door opens without moving; a repeat restarts dwell.
    pulse(NF'(1));
    check("cur_pending", int'(pending), 1);
    check("cur_door_before", int'(door_open), 0);
    step(1);
    check("cur_door_open", int'(door_open), 1);
    check("cur_floor", int'(floor), 0);
    check("cur_pending_clr", int'(pending), 0);
    step(1);
    pulse(NF'(1));
    check("cur_recall_not_latched", int'(pending), 0);
    check("cur_recall_door", int'(door_open), 1);
    step(1);
    check("cur_door_held1", int'(door_open), 1);
    step(1);
    check("cur_door_held2", int'(door_open), 1);
    step(1);
    check("cur_door_closed", int'(door_open), 0);
    check("cur_status_idle", int'(status), ST_STABLE);

    // Single call to floor 3 from floor 0.
    pulse(NF'(1) << 3);
    check("one_pending", int'(pending), 8);
    check("one_status_p1", int'(status), ST_STABLE);
    step(1);
    check("one_status_up", int'(status), ST_UP);
    check("one_floor_start", int'(floor), 0);
    step(5);
    check("one_floor_2", int'(floor), 2);
    check("one_still_up", int'(status), ST_UP);
    step(1);
    check("one_arrive_floor", int'(floor), 3);
    check("one_arrive_door", int'(door_open), 1);
    check("one_arrive_status", int'(status), ST_STABLE);
    check("one_arrive_pending", int'(pending), 0);
    step(2);
    check("one_door_last", int'(door_open), 1);
    step(1);
    check("one_door_closed", int'(door_open), 0);
    check("one_idle_status", int'(status), ST_STABLE);
    check("one_idle_floor", int'(floor), 3);

    // SCAN: moving up at 5 toward 7, then calls at 2 and 9.
    pulse(NF'(1) << 7);
    wait_floor(5, 30);
    check("scan_at5_status", int'(status), ST_UP);
    check("scan_at5_pending", int'(pending), 128);
    pulse((NF'(1) << 2) | (NF'(1) << 9));
    run_route(100);
    exp_seq = '{ST_UP, ST_STABLE, ST_UP, ST_STABLE, ST_DOWN, ST_STABLE};
    check("scan_seq_len", seq_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("scan_seq_%0d", i), (i < seq_q.size()) ? seq_q[i] : -1, exp_seq[i]);
    check("scan_stops", stop_q.size(), 3);
    check("scan_stop0", (stop_q.size() > 0) ? stop_q[0] : -1, 7);
    check("scan_stop1", (stop_q.size() > 1) ? stop_q[1] : -1, 9);
    check("scan_stop2", (stop_q.size() > 2) ? stop_q[2] : -1, 2);

    // Boundaries: top floor then bottom floor, no overrun or wrap.
    pulse(NF'(1) << 9);
    step(3);
    pulse(NF'(1));
    run_route(150);
    exp_b = '{ST_UP, ST_STABLE, ST_DOWN, ST_STABLE};
    check("bnd_seq_len", seq_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bnd_seq_%0d", i), (i < seq_q.size()) ? seq_q[i] : -1, exp_b[i]);
    check("bnd_max_floor", max_fl, 9);
    check("bnd_final_floor", int'(floor), 0);
    check("bnd_stop0", (stop_q.size() > 0) ? stop_q[0] : -1, 9);
    check("bnd_stop1", (stop_q.size() > 1) ? stop_q[1] : -1, 0);

    // Tick gating: freeze mid-segment, latching continues.
    pulse(NF'(1) << 4);
    wait_floor(1, 20);
    step(1);
    tick = 1'b0;
    step(10);
    pulse(NF'(1) << 8);
    step(39);
    check("gate_floor_frozen", int'(floor), 1);
    check("gate_status", int'(status), ST_UP);
    check("gate_pending", int'(pending), 272);
    tick = 1'b1;
    step(1);
    check("gate_resume_floor", int'(floor), 2);

    // Mid-move reset at floor 3.
    wait_floor(3, 10);
    check("mrst_moving", int'(status), ST_UP);
    rst = 1'b1;
    #1;
    check("mrst_floor", int'(floor), 0);
    check("mrst_status", int'(status), ST_STABLE);
    check("mrst_door", int'(door_open), 0);
    check("mrst_pending", int'(pending), 0);
    step(2);
    check("mrst_held_floor", int'(floor), 0);
    rst = 1'b0;
    step(10);
    check("mrst_idle_status", int'(status), ST_STABLE);
    check("mrst_idle_floor", int'(floor), 0);
    check("mrst_idle_pending", int'(pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Sequences the elevator car: latches floor calls, schedules travel with a collective (SCAN) policy, times the motion and door phases, and produces the floor number and direction status.
- Its outputs feed the four-digit seven-segment display driver directly.
  - floor goes to digit 0.
  - status goes to digit 3, shown as 10+status: A=up, b=down, C=stable.
- Sits between the switch/button input logic and the display.
- All timing runs off an external one-cycle tick from the clock divider.

Parameters:
- NUM_FLOORS, 10, number of floors (2..10) so the floor index fits one display digit (0..9).
- MOVE_TICKS, 4, ticks needed to travel one floor (>=1).
- DOOR_TICKS, 6, ticks the door stays open at each stop (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-clk-wide timing enable from the divider
- call_req  input  NUM_FLOORS  call buttons, bit i = floor i; level or pulse, sampled every clk
- floor  output  4  current car floor, 0..NUM_FLOORS-1
- status  output  2  00=UP, 01=DOWN, 10=STABLE; 11 never driven
- door_open  output  1  high while in DOOR state
- pending  output  NUM_FLOORS  registered outstanding calls

Behaviour:
- Reset (async, rst=1) forces the following; all are held while rst is high:
  - state=IDLE, floor=0, status=10, door_open=0, pending=0
  - dir=UP (internal last-direction flag)
  - move_cnt=0, door_cnt=0
- Call latching:
  - Each clk: pending <= pending | call_req, with the stop clear below.
  - Calls are visible on pending one clk after assertion.
  - The FSM decides only from registered pending, so a call in cycle n can change state at edge n+2 at the earliest.
- Stop clear:
  - Bit floor of pending is cleared on entering DOOR and held clear for the whole DOOR state.
  - A call for the current floor during DOOR restarts door_cnt and is not latched.
- Definitions: above = |pending bits > floor; below = |pending bits < floor.
- IDLE (status=10):
  - If pending[floor] -> DOOR.
  - Else if above and (dir==UP or !below) -> MOVE_UP, dir=UP.
  - Else if below -> MOVE_DOWN, dir=DOWN.
  - Else stay.
- MOVE_UP / MOVE_DOWN (status=00 / 01):
  - On each tick, move_cnt increments.
  - On the tick where move_cnt==MOVE_TICKS-1: move_cnt<=0 and floor<=floor±1.
  - After arrival:
    - If pending at the new floor -> DOOR (door_cnt=0).
    - Else stay in the move state; a target always exists ahead because pending bits only clear at stops.
  - Never increments past NUM_FLOORS-1 or decrements below 0. Any scheduling that would do so is a design bug and must be flagged by an assertion.
- DOOR (status=10, door_open=1):
  - door_cnt increments on tick.
  - On the tick where door_cnt==DOOR_TICKS-1:
    - If requests remain ahead in dir -> move the same way.
    - Else if requests remain in the opposite direction -> reverse (dir flips).
    - Else -> IDLE.
- Simultaneous events:
  - A call arriving on the same clk as an arrival is latched but is not considered until the next clk.
  - Calls at several floors are served in floor order along the current direction.
- tick low: counters and floor hold; call latching continues.
- Mid-operation reset:
  - Returns immediately to floor 0 / IDLE.
  - Pending calls are discarded.
  - There is no resume.

Test Plan:
- Reset: assert rst mid-MOVE_UP at floor 3 -> same cycle floor=0, status=10, door_open=0, pending=0; release -> IDLE persists with no calls.
- Single call: MOVE_TICKS=2, DOOR_TICKS=3, tick=1, pulse call_req[3] from IDLE at floor 0:
  - pending[3] at +1 clk
  - status=00 at +2
  - floor=3 after 6 further ticks, then door_open=1 for 3 ticks
  - then IDLE, status=10, pending=0
- Current-floor call:
  - call_req[0] while IDLE at floor 0 -> DOOR with no movement.
  - Repeat the call during DOOR -> door_cnt restarts, so the door stays open 3 ticks from the last call.
- SCAN ordering: car at 5 moving up with pending {7}; calls 2 and 9 -> stops 7 then 9 (direction kept), reverses, stops 2; status sequence 00,10,00,10,01,10.
- Boundaries: NUM_FLOORS=10, calls 9 then 0 -> floor never exceeds 9 or wraps below 0; assertion silent.
- tick gating: hold tick=0 for 50 clk in MOVE_UP -> floor and move_cnt frozen; call_req[8] pulsed meanwhile still appears on pending.
